// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one synchronous RAM between a CPU port and
// a host/loader port. Each access takes an ACCESS cycle (address/write driven)
// followed by a RESP cycle (ack pulse, read data from the RAM). When both
// ports are busy they alternate, so back-to-back grants skip IDLE.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    // Host / loader port
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_hold,

    // Synchronous RAM side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    typedef enum logic {
        OwnCpu  = 1'b0,
        OwnHost = 1'b1
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    owner_e              last_owner_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_we_q;
    logic                cpu_ack_q;
    logic                host_ack_q;

    logic                cpu_elig;
    logic                host_elig;
    logic                grant_valid;
    owner_e              grant_owner;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;

    // host_hold only gates the CPU; the host is always eligible.
    assign cpu_elig  = cpu_req & ~host_hold;
    assign host_elig = host_req;

    // Arbitration: pick a winner in IDLE (round-robin on ties) or hand over to
    // the other port at the end of RESP. The finishing owner is never re-granted
    // straight out of RESP, which is what gives the 2-cycle alternation.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OwnCpu;
        case (state_q)
            StIdle: begin
                if (cpu_elig && host_elig) begin
                    grant_valid = 1'b1;
                    grant_owner = (last_owner_q == OwnCpu) ? OwnHost : OwnCpu;
                end else if (cpu_elig) begin
                    grant_valid = 1'b1;
                    grant_owner = OwnCpu;
                end else if (host_elig) begin
                    grant_valid = 1'b1;
                    grant_owner = OwnHost;
                end
            end
            StResp: begin
                if (owner_q == OwnCpu && host_elig) begin
                    grant_valid = 1'b1;
                    grant_owner = OwnHost;
                end else if (owner_q == OwnHost && cpu_elig) begin
                    grant_valid = 1'b1;
                    grant_owner = OwnCpu;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_owner = OwnCpu;
            end
        endcase
    end

    // Mux the winning port's request fields onto the memory request path.
    always_comb begin
        if (grant_owner == OwnHost) begin
            sel_addr  = host_addr;
            sel_wdata = host_wdata;
            sel_we    = host_we;
        end else begin
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
            sel_we    = cpu_we;
        end
    end

    // Arbiter FSM with registered memory-side and ack outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnHost;
            last_owner_q <= OwnHost;  // so the CPU wins the first tie
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
        end else begin
            // Strobes default low; each is raised for a single cycle below.
            mem_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            case (state_q)
                StIdle, StResp: begin
                    if (grant_valid) begin
                        state_q      <= StAccess;
                        owner_q      <= grant_owner;
                        last_owner_q <= grant_owner;
                        mem_addr_q   <= sel_addr;
                        mem_wdata_q  <= sel_wdata;
                        mem_we_q     <= sel_we;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAccess: begin
                    // RAM samples the address on this edge; data and ack line up next cycle.
                    state_q    <= StResp;
                    cpu_ack_q  <= (owner_q == OwnCpu);
                    host_ack_q <= (owner_q == OwnHost);
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    // Read data only meaningful alongside the owner's ack on a read.
    assign cpu_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;
    assign cpu_stall  = cpu_req & ~cpu_ack_q;

    // Write strobe may only be up during the ACCESS cycle.
    a_we_only_in_access: assert property (
        @(posedge clk) disable iff (!rst_n) mem_we_q |-> (state_q == StAccess)
    );

    // Only one port is ever acknowledged at a time, and only in RESP.
    a_ack_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n)
        (cpu_ack_q || host_ack_q) |-> (!(cpu_ack_q && host_ack_q) && state_q == StResp)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model and an
// ack-order scoreboard checked by an independent monitor.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          host_req, host_we, host_ack, host_hold;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        bit          is_host;
        bit          we;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_hold  (host_hold),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous RAM model: unwritten locations hold a fixed pattern.
    logic [7:0] ram [256];
    bit         written [256];

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 8'hA5;
        return a ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the next expected response in order.
    always @(negedge clk) begin
        if (rst_n && (cpu_ack || host_ack)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: cpu_ack=%0b host_ack=%0b, expected none (t=%0t)",
                         cpu_ack, host_ack, $time);
            end else begin
                mon_e = sb.pop_front();
                check("dual_ack", {31'd0, cpu_ack && host_ack}, 32'd0);
                check("ack_port", {31'd0, host_ack}, {31'd0, mon_e.is_host});
                if (!mon_e.we)
                    check("rdata", {24'd0, host_ack ? host_rdata : cpu_rdata},
                          {24'd0, mon_e.data});
            end
        end
    end

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_hold = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete request on one port; counts write strobes seen meanwhile.
    task automatic do_access(input bit is_host, input bit we, input logic [7:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd);
        int  we_cnt;
        bit  got;
        exp_t e;
        we_cnt = 0;
        got = 0;
        @(negedge clk);
        e.is_host = is_host; e.we = we; e.data = exp_rd;
        sb.push_back(e);
        if (is_host) begin
            host_req = 1; host_we = we; host_addr = addr; host_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                check("wr_addr", {24'd0, mem_addr}, {24'd0, addr});
                check("wr_data", {24'd0, mem_wdata}, {24'd0, wd});
            end
            if (is_host ? host_ack : cpu_ack) got = 1;
        end
        check("ack_seen", {31'd0, got}, 32'd1);
        check("we_cycles", we_cnt, {31'd0, we});
        if (is_host) host_req = 0;
        else cpu_req = 0;
    endtask

    int  lat;
    bit  seen_ack;
    bit  stall_ok;
    exp_t e0;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #1;
        // Reset values (asynchronous, before any clock edge)
        check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr",  {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_cpu_ack",   {31'd0, cpu_ack}, 32'd0);
        check("rst_host_ack",  {31'd0, host_ack}, 32'd0);
        check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // CPU read 0x10 -> 0xA5, ack two cycles after request
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        e0.is_host = 0; e0.we = 0; e0.data = 8'hA5;
        sb.push_back(e0);
        @(negedge clk);
        check("r32_addr",  {24'd0, mem_addr}, 32'h10);
        check("r32_we",    {31'd0, mem_we}, 32'd0);
        check("r32_noack", {31'd0, cpu_ack}, 32'd0);
        check("r32_stall", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        check("r32_ack",     {31'd0, cpu_ack}, 32'd1);
        check("r32_nostall", {31'd0, cpu_stall}, 32'd0);
        cpu_req = 0;
        @(negedge clk);
        check("r32_ack_once", {31'd0, cpu_ack}, 32'd0);

        // Host write 0x3C to 0x20, then CPU reads it back
        do_access(1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
        do_access(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C);

        // Both ports saturated after reset: CPU, HOST, CPU, HOST every 2 cycles
        do_reset();
        @(negedge clk);
        e0.we = 0;
        e0.is_host = 0; e0.data = 8'h5B; sb.push_back(e0);
        e0.is_host = 1; e0.data = 8'h58; sb.push_back(e0);
        e0.is_host = 0; e0.data = 8'h5B; sb.push_back(e0);
        e0.is_host = 1; e0.data = 8'h58; sb.push_back(e0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
        host_req = 1; host_we = 0; host_addr = 8'h02;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr_cpu_ack%0d", k), {31'd0, cpu_ack},
                  {31'd0, (k == 1 || k == 5)});
            check($sformatf("rr_host_ack%0d", k), {31'd0, host_ack},
                  {31'd0, (k == 3 || k == 7)});
        end
        cpu_req = 0; host_req = 0;
        repeat (2) @(negedge clk);

        // host_hold blocks the CPU; the host is still served
        @(negedge clk);
        host_hold = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
        seen_ack = 0; stall_ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack) seen_ack = 1;
            if (!cpu_stall) stall_ok = 0;
        end
        check("hold_no_ack", {31'd0, seen_ack}, 32'd0);
        check("hold_stall",  {31'd0, stall_ok}, 32'd1);
        do_access(1'b1, 1'b0, 8'h31, 8'h00, 8'h6B);
        @(negedge clk);
        e0.is_host = 0; e0.we = 0; e0.data = 8'h6A; sb.push_back(e0);
        host_hold = 0;
        lat = 0; seen_ack = 0;
        for (int i = 1; i <= 10 && !seen_ack; i++) begin
            @(negedge clk);
            if (cpu_ack) begin seen_ack = 1; lat = i; end
        end
        check("hold_release_lat", lat, 32'd2);
        cpu_req = 0;
        repeat (2) @(negedge clk);

        // Reset during ACCESS of a CPU write
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
        @(negedge clk);
        check("r36_we_pre", {31'd0, mem_we}, 32'd1);
        #1 rst_n = 0;
        #1;
        check("r36_we_async",    {31'd0, mem_we}, 32'd0);
        check("r36_addr_async",  {24'd0, mem_addr}, 32'd0);
        check("r36_wdata_async", {24'd0, mem_wdata}, 32'd0);
        cpu_req = 0; cpu_we = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        seen_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack || host_ack) seen_ack = 1;
        end
        check("r36_no_ack",  {31'd0, seen_ack}, 32'd0);
        check("r36_addr",    {24'd0, mem_addr}, 32'd0);
        check("r36_wdata",   {24'd0, mem_wdata}, 32'd0);
        check("r36_we",      {31'd0, mem_we}, 32'd0);
        check("r36_not_written", {31'd0, written[8'h40]}, 32'd0);

        // host_hold raised in the CPU ACCESS cycle; a short host pulse is discarded
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h50;
        e0.is_host = 0; e0.we = 0; e0.data = 8'h0A; sb.push_back(e0);
        @(negedge clk);
        check("r37_access_addr", {24'd0, mem_addr}, 32'h50);
        host_hold = 1;
        host_req = 1; host_we = 0; host_addr = 8'h60;
        @(negedge clk);
        check("r37_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 0;
        host_req = 0;
        @(negedge clk);
        cpu_req = 1; cpu_addr = 8'h51;
        seen_ack = 0; stall_ok = 1;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || host_ack) seen_ack = 1;
            if (!cpu_stall) stall_ok = 0;
        end
        check("r37_blocked", {31'd0, seen_ack}, 32'd0);
        check("r37_stall",   {31'd0, stall_ok}, 32'd1);
        e0.is_host = 0; e0.we = 0; e0.data = 8'h0B; sb.push_back(e0);
        host_hold = 0;
        lat = 0; seen_ack = 0;
        for (int i = 1; i <= 10 && !seen_ack; i++) begin
            @(negedge clk);
            if (cpu_ack) begin seen_ack = 1; lat = i; end
        end
        check("r37_release_lat", lat, 32'd2);
        cpu_req = 0;
        repeat (4) @(negedge clk);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
